// File: rtl/multi_gate_sweep.sv
// Registered N-input gate (AND/OR/XOR/NAND) with a built-in exhaustive truth-table sweeper.
// Optional simulation trace: define MULTI_GATE_SWEEP_TRACE_EN.
module multi_gate_sweep #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic             in_valid,
  input  logic             start,
  output logic             o1,
  output logic             o1_valid,
  output logic [WIDTH-1:0] sweep_vec,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   ones_count
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  // Counter is one bit wider than the vector so the terminal compare never wraps.
  localparam logic [WIDTH:0] LAST = {1'b0, {WIDTH{1'b1}}};

  state_t         state;
  logic [WIDTH:0] cnt;
  logic [1:0]     op_q;
  logic           cur_bit;

  function automatic logic gate_f(input logic [WIDTH-1:0] v, input logic [1:0] o);
    case (o)
      2'b00:   return &v;
      2'b01:   return |v;
      2'b10:   return ^v;
      default: return ~&v;
    endcase
  endfunction

  assign cur_bit = gate_f(cnt[WIDTH-1:0], op_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      o1         <= 1'b0;
      o1_valid   <= 1'b0;
      sweep_vec  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ones_count <= '0;
    end else begin
      o1_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          // start wins over a same-cycle in_valid; that request is dropped.
          if (start) begin
            state      <= SWEEP;
            op_q       <= op;
            cnt        <= '0;
            ones_count <= '0;
            busy       <= 1'b1;
          end else if (in_valid) begin
            o1        <= gate_f(in1, op);
            sweep_vec <= in1;
            o1_valid  <= 1'b1;
          end
        end
        SWEEP: begin
          o1         <= cur_bit;
          sweep_vec  <= cnt[WIDTH-1:0];
          o1_valid   <= 1'b1;
          ones_count <= ones_count + {{WIDTH{1'b0}}, cur_bit};
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + {{WIDTH{1'b0}}, 1'b1};
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MULTI_GATE_SWEEP_TRACE_EN
  always @(posedge clk) begin
    if (o1_valid) $display(" vec=%b op=%b o=%b ", sweep_vec, op_q, o1);
    if (done) $display(" sweep done ones=%d ", ones_count);
  end
`else
`endif

endmodule

// File: tb/tb_multi_gate_sweep.sv
// Bench for multi_gate_sweep: a WIDTH=2 and a WIDTH=3 instance, each with a result scoreboard.
module tb_multi_gate_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_2, start_2, iv_2, o1_2, ov_2, busy_2, done_2;
  logic [1:0] op_2, in1_2, sv_2;
  logic [2:0] ones_2;

  logic       rst_3, start_3, iv_3, o1_3, ov_3, busy_3, done_3;
  logic [1:0] op_3;
  logic [2:0] in1_3, sv_3;
  logic [3:0] ones_3;

  int n_tests = 0;
  int n_fail  = 0;

  // Entry layout: {o1, vec[2:0]}
  logic [3:0] exp2_q[$];
  logic [3:0] exp3_q[$];

  multi_gate_sweep #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst_2), .op(op_2), .in1(in1_2), .in_valid(iv_2), .start(start_2),
    .o1(o1_2), .o1_valid(ov_2), .sweep_vec(sv_2), .busy(busy_2), .done(done_2),
    .ones_count(ones_2)
  );

  multi_gate_sweep #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst_3), .op(op_3), .in1(in1_3), .in_valid(iv_3), .start(start_3),
    .o1(o1_3), .o1_valid(ov_3), .sweep_vec(sv_3), .busy(busy_3), .done(done_3),
    .ones_count(ones_3)
  );

  // Reference gate built from a population count.
  function automatic logic ref_f(input logic [2:0] v, input logic [1:0] o, input int w);
    int pop = 0;
    for (int i = 0; i < w; i++) pop += int'(v[i]);
    case (o)
      2'b00:   return pop == w;
      2'b01:   return pop != 0;
      2'b10:   return (pop % 2) == 1;
      default: return pop != w;
    endcase
  endfunction

  // Scoreboards: every o1_valid cycle consumes one expected entry.
  always @(negedge clk) begin
    logic [3:0] e;
    if (ov_2) begin
      n_tests++;
      if (exp2_q.size() == 0) begin
        n_fail++;
        $display("FAIL mon2_unexpected got={o,vec}=%b required=no result", {o1_2, 1'b0, sv_2});
      end else begin
        e = exp2_q.pop_front();
        if ({o1_2, 1'b0, sv_2} !== e) begin
          n_fail++;
          $display("FAIL mon2_result got={o,vec}=%b required=%b", {o1_2, 1'b0, sv_2}, e);
        end
      end
    end
    if (ov_3) begin
      n_tests++;
      if (exp3_q.size() == 0) begin
        n_fail++;
        $display("FAIL mon3_unexpected got={o,vec}=%b required=no result", {o1_3, sv_3});
      end else begin
        e = exp3_q.pop_front();
        if ({o1_3, sv_3} !== e) begin
          n_fail++;
          $display("FAIL mon3_result got={o,vec}=%b required=%b", {o1_3, sv_3}, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int inst, input logic s, input logic iv, input logic [2:0] v,
                        input logic [1:0] o);
    if (inst == 2) begin
      start_2 = s; iv_2 = iv; in1_2 = v[1:0]; op_2 = o;
    end else begin
      start_3 = s; iv_3 = iv; in1_3 = v; op_3 = o;
    end
  endtask

  task automatic push_exp(input int inst, input logic [2:0] v, input logic [1:0] o);
    if (inst == 2) exp2_q.push_back({ref_f(v, o, 2), 1'b0, v[1:0]});
    else exp3_q.push_back({ref_f(v, o, 3), v});
  endtask

  task automatic check_empty(input int inst, input string name);
    int sz;
    sz = (inst == 2) ? exp2_q.size() : exp3_q.size();
    n_tests++;
    if (sz != 0) begin
      n_fail++;
      $display("FAIL %s_missing_results got=%0d pending required=0", name, sz);
    end
  endtask

  task automatic test_reset();
    set_in(2, 1'b1, 1'b0, 3'd0, 2'b00);
    step();
    set_in(2, 1'b0, 1'b0, 3'd0, 2'b00);
    push_exp(2, 3'd0, 2'b00);
    step();
    rst_2 = 1'b1;
    step();
    step();
    rst_2 = 1'b0;
    n_tests++;
    if ({o1_2, ov_2, sv_2, busy_2, done_2, ones_2} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b required=0", {o1_2, ov_2, sv_2, busy_2, done_2, ones_2});
    end
    set_in(2, 1'b0, 1'b1, 3'b011, 2'b00);
    push_exp(2, 3'b011, 2'b00);
    step();
    set_in(2, 1'b0, 1'b0, 3'd0, 2'b00);
    n_tests++;
    if ({ov_2, o1_2} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_first_eval got={valid,o1}=%b required=11", {ov_2, o1_2});
    end
    step();
    check_empty(2, "reset");
  endtask

  task automatic test_single();
    set_in(2, 1'b0, 1'b1, 3'b011, 2'b00);
    push_exp(2, 3'b011, 2'b00);
    step();
    set_in(2, 1'b0, 1'b1, 3'b001, 2'b00);
    push_exp(2, 3'b001, 2'b00);
    step();
    n_tests++;
    if ({ov_2, o1_2, sv_2} !== 4'b1001) begin
      n_fail++;
      $display("FAIL single_back_to_back got={valid,o1,vec}=%b required=1001", {ov_2, o1_2, sv_2});
    end
    set_in(2, 1'b0, 1'b1, 3'b011, 2'b11);
    push_exp(2, 3'b011, 2'b11);
    step();
    set_in(2, 1'b0, 1'b0, 3'd0, 2'b00);
    n_tests++;
    if ({ov_2, o1_2} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_nand got={valid,o1}=%b required=10", {ov_2, o1_2});
    end
    step();
    n_tests++;
    if (ov_2 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_valid_drop got=%b required=0", ov_2);
    end
    check_empty(2, "single");
  endtask

  // mode 0: clean sweep; 1: hostile inputs mid-sweep; 2: start together with in_valid
  task automatic test_sweep(input int inst, input logic [1:0] op, input int mode);
    int n = 1 << inst;
    int busy_cyc = 0;
    int done_cnt = 0;
    int done_at = -1;
    int exp_ones = 0;
    logic b, d;
    logic [3:0] ones;
    set_in(inst, 1'b1, mode == 2, 3'b111, op);
    for (int k = 0; k < n; k++) begin
      push_exp(inst, 3'(k), op);
      exp_ones += int'(ref_f(3'(k), op, inst));
    end
    for (int c = 0; c <= n + 1; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 0) set_in(inst, 1'b0, 1'b0, 3'd0, op);
      if (mode == 1 && c >= 1 && c <= n - 3)
        set_in(inst, 1'($urandom_range(0, 1)), 1'b1, 3'b111, ~op);
      if (mode == 1 && c == n - 2) set_in(inst, 1'b0, 1'b0, 3'd0, op);
      b    = (inst == 2) ? busy_2 : busy_3;
      d    = (inst == 2) ? done_2 : done_3;
      ones = (inst == 2) ? {1'b0, ones_2} : ones_3;
      if (b) busy_cyc++;
      if (d) begin
        done_cnt++;
        done_at = c;
      end
      if (c == n) begin
        n_tests++;
        if (ones !== 4'(exp_ones)) begin
          n_fail++;
          $display("FAIL sweep_w%0d_op%b_ones got=%0d required=%0d", inst, op, ones, exp_ones);
        end
      end
    end
    n_tests++;
    if (busy_cyc != n) begin
      n_fail++;
      $display("FAIL sweep_w%0d_op%b_busy got=%0d cycles required=%0d", inst, op, busy_cyc, n);
    end
    n_tests++;
    if (done_cnt != 1 || done_at != n) begin
      n_fail++;
      $display("FAIL sweep_w%0d_op%b_done got=%0d pulses at %0d required=1 at %0d",
               inst, op, done_cnt, done_at, n);
    end
    n_tests++;
    if (ones !== 4'(exp_ones)) begin
      n_fail++;
      $display("FAIL sweep_w%0d_op%b_ones_hold got=%0d required=%0d", inst, op, ones, exp_ones);
    end
    check_empty(inst, "sweep");
  endtask

  task automatic test_back_to_back();
    test_sweep(3, 2'b10, 0);
    test_sweep(3, 2'b01, 0);
    test_sweep(3, 2'b11, 0);
    test_sweep(3, 2'b00, 0);
  endtask

  task automatic test_ignore();
    test_sweep(3, 2'b10, 1);
  endtask

  task automatic test_simultaneous();
    test_sweep(3, 2'b00, 2);
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    set_in(3, 1'b1, 1'b0, 3'd0, 2'b01);
    for (int k = 0; k < 3; k++) push_exp(3, 3'(k), 2'b01);
    step();
    set_in(3, 1'b0, 1'b0, 3'd0, 2'b01);
    step();
    step();
    step();
    n_tests++;
    if ({ov_3, sv_3} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_mid_position got={valid,vec}=%b required=1010", {ov_3, sv_3});
    end
    rst_3 = 1'b1;
    step();
    rst_3 = 1'b0;
    n_tests++;
    if ({busy_3, ov_3, done_3, ones_3} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_mid_clear got={busy,valid,done,ones}=%b required=0",
               {busy_3, ov_3, done_3, ones_3});
    end
    for (int c = 0; c < 12; c++) begin
      step();
      if (done_3 || ov_3 || busy_3) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet got=%0d active cycles required=0", bad);
    end
    check_empty(3, "reset_mid");
    test_sweep(3, 2'b01, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_2 = 1'b1;
    rst_3 = 1'b1;
    set_in(2, 1'b0, 1'b0, 3'd0, 2'b00);
    set_in(3, 1'b0, 1'b0, 3'd0, 2'b00);
    step();
    step();
    rst_2 = 1'b0;
    rst_3 = 1'b0;
    step();
    test_reset();
    test_single();
    test_sweep(2, 2'b00, 0);
    test_back_to_back();
    test_ignore();
    test_simultaneous();
    test_reset_mid();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
